// File: rtl/wb_writer_pkg.sv
// Shared widths, load funct3 codes, FSM encoding and the latched load context.
package wb_writer_pkg;

    localparam int unsigned REG_BUS_WIDTH  = 5;
    localparam int unsigned DATA_BUS_WIDTH = 32;

    localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD = '0;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE    = 1'b0,
        WB_WAIT_LD = 1'b1
    } wb_state_e;

    // Everything about an accepted load that is needed when its data returns.
    typedef struct packed {
        logic [REG_BUS_WIDTH-1:0] rd;
        logic                     rd_we;
        logic [2:0]               funct3;
        logic [1:0]               addr_lo;
    } ld_ctx_t;

endpackage

// File: rtl/wb_writer_if.sv
// MEM-stage handshake, dmem response and register-file write port of the write-back stage.
interface wb_writer_if #(
    parameter int unsigned CNT_WIDTH = 64
);
    import wb_writer_pkg::*;

    logic                      mem_vld;
    logic                      mem_rdy;
    logic [REG_BUS_WIDTH-1:0]  mem_rd;
    logic                      mem_rd_we;
    logic                      mem_is_load;
    logic [2:0]                mem_ld_funct3;
    logic [1:0]                mem_addr_lo;
    logic [DATA_BUS_WIDTH-1:0] mem_alu_data;
    logic                      dmem_rvld;
    logic [DATA_BUS_WIDTH-1:0] dmem_rdata;
    logic [REG_BUS_WIDTH-1:0]  reg_waddr;
    logic                      reg_waddr_vld;
    logic [DATA_BUS_WIDTH-1:0] reg_wdata;
    logic [CNT_WIDTH-1:0]      instret;
    logic                      busy;

    // Upstream side: MEM stage plus data memory.
    modport master (
        output mem_vld, mem_rd, mem_rd_we, mem_is_load, mem_ld_funct3,
               mem_addr_lo, mem_alu_data, dmem_rvld, dmem_rdata,
        input  mem_rdy, reg_waddr, reg_waddr_vld, reg_wdata, instret, busy
    );

    // Write-back stage side.
    modport slave (
        input  mem_vld, mem_rd, mem_rd_we, mem_is_load, mem_ld_funct3,
               mem_addr_lo, mem_alu_data, dmem_rvld, dmem_rdata,
        output mem_rdy, reg_waddr, reg_waddr_vld, reg_wdata, instret, busy
    );

endinterface

// File: rtl/wb_writer_load_extend.sv
// Selects the byte/halfword lane of an aligned load word and sign/zero extends it.
module wb_writer_load_extend
    import wb_writer_pkg::*;
(
    input  logic [2:0]                funct3,
    input  logic [1:0]                addr_lo,
    input  logic [DATA_BUS_WIDTH-1:0] rdata,
    output logic [DATA_BUS_WIDTH-1:0] ext_data_c
);

    localparam int unsigned BYTE_PAD = DATA_BUS_WIDTH - 8;
    localparam int unsigned HALF_PAD = DATA_BUS_WIDTH - 16;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane pick then extension; unknown funct3 falls back to a full word.
    always_comb begin
        byte_lane  = rdata[{addr_lo, 3'b000} +: 8];
        half_lane  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext_data_c = rdata;
        case (funct3)
            LD_LB:   ext_data_c = {{BYTE_PAD{byte_lane[7]}}, byte_lane};
            LD_LH:   ext_data_c = {{HALF_PAD{half_lane[15]}}, half_lane};
            LD_LW:   ext_data_c = rdata;
            LD_LBU:  ext_data_c = {{BYTE_PAD{1'b0}}, byte_lane};
            LD_LHU:  ext_data_c = {{HALF_PAD{1'b0}}, half_lane};
            default: ext_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: retires MEM-stage instructions, waits on loads, drives the xreg write port.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    wb_writer_if.slave  bus
);

    wb_state_e                 state_q, state_d;
    ld_ctx_t                   ctx_q, ctx_d;
    logic [REG_BUS_WIDTH-1:0]  waddr_q, waddr_d;
    logic                      wvld_q, wvld_d;
    logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]      instret_q, instret_d;
    logic                      rdy_q, rdy_d;
    logic                      busy_q, busy_d;
    logic                      accept;
    logic [DATA_BUS_WIDTH-1:0] ld_data_c;

    wb_writer_load_extend u_load_extend (
        .funct3     (ctx_q.funct3),
        .addr_lo    (ctx_q.addr_lo),
        .rdata      (bus.dmem_rdata),
        .ext_data_c (ld_data_c)
    );

    // State and output registers; reset abandons any outstanding load.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= WB_IDLE;
            ctx_q     <= '0;
            waddr_q   <= '0;
            wvld_q    <= 1'b0;
            wdata_q   <= ZERO_WORD;
            instret_q <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctx_q     <= ctx_d;
            waddr_q   <= waddr_d;
            wvld_q    <= wvld_d;
            wdata_q   <= wdata_d;
            instret_q <= instret_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    // Next state and next register values; write fields return to zero unless a write is due.
    always_comb begin
        state_d   = state_q;
        ctx_d     = ctx_q;
        waddr_d   = '0;
        wvld_d    = 1'b0;
        wdata_d   = ZERO_WORD;
        instret_d = instret_q;
        accept    = bus.mem_vld & rdy_q;

        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (bus.mem_is_load) begin
                        ctx_d.rd      = bus.mem_rd;
                        ctx_d.rd_we   = bus.mem_rd_we;
                        ctx_d.funct3  = bus.mem_ld_funct3;
                        ctx_d.addr_lo = bus.mem_addr_lo;
                        state_d       = WB_WAIT_LD;
                    end else begin
                        wvld_d    = bus.mem_rd_we & (bus.mem_rd != '0);
                        waddr_d   = bus.mem_rd;
                        wdata_d   = bus.mem_alu_data;
                        instret_d = instret_q + CNT_WIDTH'(1);
                    end
                end
            end
            WB_WAIT_LD: begin
                if (bus.dmem_rvld) begin
                    wvld_d    = ctx_q.rd_we & (ctx_q.rd != '0);
                    waddr_d   = ctx_q.rd;
                    wdata_d   = ld_data_c;
                    instret_d = instret_q + CNT_WIDTH'(1);
                    state_d   = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        rdy_d  = (state_d == WB_IDLE);
        busy_d = (state_d == WB_WAIT_LD);
    end

    assign bus.mem_rdy       = rdy_q;
    assign bus.busy          = busy_q;
    assign bus.reg_waddr     = waddr_q;
    assign bus.reg_waddr_vld = wvld_q;
    assign bus.reg_wdata     = wdata_q;
    assign bus.instret       = instret_q;

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back stage that owns the write end of the integer register file port: drives reg_waddr, reg_waddr_vld and reg_wdata into the xreg block.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Waits for data-memory load responses and applies load byte/halfword selection and sign/zero extension.
- Counts retired instructions.

Parameters:
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk_i  in  1  core clock; all state on posedge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- mem_vld_i  in  1  MEM stage presents an instruction.
- mem_rdy_o  out  1  wb_writer can accept; handshake completes when mem_vld_i & mem_rdy_o.
- mem_rd_i  in  `REG_BUS_WIDTH  destination register index.
- mem_rd_we_i  in  1  instruction writes rd.
- mem_is_load_i  in  1  instruction is a load; its data comes from dmem.
- mem_ld_funct3_i  in  3  load type (LB/LH/LW/LBU/LHU).
- mem_addr_lo_i  in  2  load address bits [1:0].
- mem_alu_data_i  in  `DATA_BUS_WIDTH  result for non-loads.
- dmem_rvld_i  in  1  load response valid (one-cycle pulse).
- dmem_rdata_i  in  `DATA_BUS_WIDTH  aligned 32-bit word read.
- reg_waddr_o  out  `REG_BUS_WIDTH  to xreg write address.
- reg_waddr_vld_o  out  1  to xreg write enable.
- reg_wdata_o  out  `DATA_BUS_WIDTH  to xreg write data.
- instret_o  out  CNT_WIDTH  retired-instruction count.
- busy_o  out  1  a load is outstanding.

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE
  - reg_waddr_o=0, reg_waddr_vld_o=0, reg_wdata_o=`ZERO_WORD
  - instret_o=0, busy_o=0
  - mem_rdy_o=0 while rst_n_i low
- The write outputs are registers. Each write is a single-cycle pulse, and at most one write happens per cycle.
- FSM states: IDLE, WAIT_LD.
- IDLE:
  - mem_rdy_o=1.
  - Accept a non-load in cycle N: in cycle N+1, reg_waddr_vld_o = mem_rd_we_i & (mem_rd_i!=0), reg_waddr_o = mem_rd_i, reg_wdata_o = mem_alu_data_i. instret increments at N+1. Stay in IDLE, so back-to-back accepts give one write per cycle.
  - Accept a load: latch rd, rd_we, funct3 and addr_lo, then go to WAIT_LD. busy_o=1 from N+1.
- WAIT_LD:
  - mem_rdy_o=0.
  - On dmem_rvld_i in cycle M: in cycle M+1 the write pulse carries the extended data (suppressed if rd==0 or !rd_we). instret increments, state returns to IDLE, busy_o=0, and mem_rdy_o=1 in M+1.
  - The response is never accepted in the accept cycle itself. Minimum load latency is accept N, rvld N+1, write N+2.
- dmem_rvld_i while in IDLE is ignored: no write, no count.
- Load extension, where byte = addr_lo, half = addr_lo[1]:
  - LB (000): sign-extend byte lane.
  - LH (001): sign-extend half lane.
  - LW (010): whole word; addr_lo ignored.
  - LBU (100): zero-extend byte lane.
  - LHU (101): zero-extend half lane.
  - Other funct3 values: treat as LW.
- rd==0: write is never asserted; the instruction still retires and counts.
- instret_o wraps modulo 2^CNT_WIDTH.
- Reset mid-load: the outstanding load is abandoned with no write. A dmem_rvld_i after reset release is ignored (IDLE).
- Outputs are cleared one cycle after a pulse unless a new write is due that cycle.

Decomposition:
- `define constants in param.v: LD_LB/LD_LH/LD_LW/LD_LBU/LD_LHU funct3 codes, WB_IDLE/WB_WAIT_LD state encodings. REG_BUS_WIDTH, DATA_BUS_WIDTH and ZERO_WORD already exist there.
- One combinational sub-module, load_extend: inputs funct3, addr_lo, rdata; output extended word. It is reused by any future load path.

Test Plan:
- Back-to-back ALU ops: rd=5 data 0x1234_5678, then rd=6 data 0xDEAD_BEEF, accepted cycles 1,2 -> write pulses at cycles 2,3 with the same addr/data. instret=2.
- LB with addr_lo=3, dmem word 0x80FF_0011, rvld 3 cycles after accept -> mem_rdy_o=0 until the response. Write data 0xFFFF_FF80, one cycle after rvld. busy_o high throughout the wait.
- LHU addr_lo=2 on word 0x8001_7F02 -> 0x0000_8001. LH on the same word -> 0xFFFF_8001. LW -> 0x8001_7F02.
- ALU op with rd=0 and rd_we=1, data 0xFFFF_FFFF -> reg_waddr_vld_o stays 0 and instret increments by 1. A stray dmem_rvld_i in IDLE -> no write, instret unchanged.
- Reset asserted while in WAIT_LD, then a response arrives after release -> no write, instret=0, mem_rdy_o=1.
- Force instret to 2^CNT_WIDTH-1 (CNT_WIDTH=4: 15 retires) then retire one more -> instret_o=0.
